// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
//
// Pipeline-side bus between the five-stage core and pipeline_ctrl.
//   if_busy, mem_busy, ld_hazard : wait / hazard lines from fetch, memory, decode
//   mem_en, mem_pc, mem_ctrl_op,
//   mem_dst_addr, mem_exp_code,
//   mem_out                      : MEM-stage instruction as seen by the controller
//   *_stall, *_flush             : per-stage stall and flush controls
//   new_pc                       : redirect target, valid while if_flush = 1
//
// Modports: master = pipeline (drives busy/hazard/MEM fields),
//           slave  = pipeline_ctrl (drives stalls, flushes, new_pc).
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if;
    logic        if_busy;
    logic        mem_busy;
    logic        ld_hazard;
    logic        mem_en;
    logic [29:0] mem_pc;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;
    logic        if_stall;
    logic        id_stall;
    logic        ex_stall;
    logic        mem_stall;
    logic        if_flush;
    logic        id_flush;
    logic        ex_flush;
    logic        mem_flush;
    logic [29:0] new_pc;

    modport master (
        output if_busy, mem_busy, ld_hazard,
        output mem_en, mem_pc, mem_ctrl_op, mem_dst_addr, mem_exp_code, mem_out,
        input  if_stall, id_stall, ex_stall, mem_stall,
        input  if_flush, id_flush, ex_flush, mem_flush,
        input  new_pc
    );

    modport slave (
        input  if_busy, mem_busy, ld_hazard,
        input  mem_en, mem_pc, mem_ctrl_op, mem_dst_addr, mem_exp_code, mem_out,
        output if_stall, id_stall, ex_stall, mem_stall,
        output if_flush, id_flush, ex_flush, mem_flush,
        output new_pc
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Pipeline controller for the five-stage core: per-stage stall/flush
// generation, control-register file, WRCR/EXRT commit and exception /
// interrupt entry, all decided from the MEM stage.
//
// Ports:
//   clk, reset_     : core clock, asynchronous active-low reset
//   pl (slave)      : pipeline bus (busy/hazard in, MEM fields in,
//                     stalls/flushes/new_pc out)
//   creg_rd_addr    : control-register read address from the decoder
//   creg_rd_data    : combinational control-register read data
//   exe_mode        : 1 = kernel, 0 = user
//   irq             : level-sensitive external interrupt lines
//   int_detect      : pending, unmasked interrupt while int_en = 1
//
// Build option: define PIPELINE_CTRL_IRQ_EN to implement interrupt
// detection, INT_MASK (reg 5) and the IRQ view (reg 6). Without it those
// registers read 0, ignore writes, and int_detect is tied low.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter logic [29:0] RESET_VECTOR = 30'h0,
    parameter int          IRQ_W        = 8
) (
    input  logic             clk,
    input  logic             reset_,
    pipeline_ctrl_if.slave   pl,
    input  logic [4:0]       creg_rd_addr,
    output logic [31:0]      creg_rd_data,
    output logic             exe_mode,
    input  logic [IRQ_W-1:0] irq,
    output logic             int_detect
);
    localparam logic [1:0] CTRL_OP_WRCR    = 2'd1;
    localparam logic [1:0] CTRL_OP_EXRT    = 2'd2;
    localparam logic [2:0] ISA_EXP_NO_EXP  = 3'd0;
    localparam logic [2:0] ISA_EXP_EXT_INT = 3'd1;
    localparam logic       CPU_KERNEL_MODE = 1'b1;

    localparam logic [4:0] CREG_STATUS     = 5'd0;
    localparam logic [4:0] CREG_PRE_STATUS = 5'd1;
    localparam logic [4:0] CREG_EPC        = 5'd2;
    localparam logic [4:0] CREG_EXP_VECTOR = 5'd3;
    localparam logic [4:0] CREG_CAUSE      = 5'd4;
    localparam logic [4:0] CREG_INT_MASK   = 5'd5;
    localparam logic [4:0] CREG_IRQ        = 5'd6;

    typedef enum logic {ST_BOOT, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic        exe_mode_q, exe_mode_d;
    logic        int_en_q, int_en_d;
    logic [31:0] pre_status_q, pre_status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] exp_vector_q, exp_vector_d;
    logic [2:0]  cause_q, cause_d;
`ifdef PIPELINE_CTRL_IRQ_EN
    logic [IRQ_W-1:0] int_mask_q, int_mask_d;
`endif

    logic        stall;
    logic        stall_all;
    logic        hazard_stall;
    logic        flush_all;
    logic        id_bubble;
    logic [29:0] new_pc_c;

`ifdef PIPELINE_CTRL_IRQ_EN
    assign int_detect = int_en_q & (|(irq & ~int_mask_q));
`else
    logic unused_irq;
    assign unused_irq = ^irq;
    assign int_detect = 1'b0;
`endif

    assign stall    = pl.if_busy | pl.mem_busy;
    assign exe_mode = exe_mode_q;

    // Control-register read port; no bypass from a WRCR being committed.
    always_comb begin
        creg_rd_data = 32'h0;
        case (creg_rd_addr)
            CREG_STATUS:     creg_rd_data = {30'b0, int_en_q, exe_mode_q};
            CREG_PRE_STATUS: creg_rd_data = pre_status_q;
            CREG_EPC:        creg_rd_data = epc_q;
            CREG_EXP_VECTOR: creg_rd_data = exp_vector_q;
            CREG_CAUSE:      creg_rd_data = {29'b0, cause_q};
`ifdef PIPELINE_CTRL_IRQ_EN
            CREG_INT_MASK:   creg_rd_data[IRQ_W-1:0] = int_mask_q;
            CREG_IRQ:        creg_rd_data[IRQ_W-1:0] = irq;
`endif
            default:         creg_rd_data = 32'h0;
        endcase
    end

    // Next state, register updates and pipeline controls.
    always_comb begin
        state_d      = state_q;
        exe_mode_d   = exe_mode_q;
        int_en_d     = int_en_q;
        pre_status_d = pre_status_q;
        epc_d        = epc_q;
        exp_vector_d = exp_vector_q;
        cause_d      = cause_q;
`ifdef PIPELINE_CTRL_IRQ_EN
        int_mask_d   = int_mask_q;
`endif
        stall_all    = 1'b0;
        hazard_stall = 1'b0;
        flush_all    = 1'b0;
        id_bubble    = 1'b0;
        new_pc_c     = '0;

        case (state_q)
            ST_BOOT: begin
                // Stalls stay low here so the boot redirect always lands.
                state_d   = ST_RUN;
                flush_all = 1'b1;
                new_pc_c  = RESET_VECTOR;
            end
            default: begin
                stall_all = stall;
                if (!stall && pl.mem_en) begin
                    if ((pl.mem_exp_code != ISA_EXP_NO_EXP) || int_detect) begin
                        flush_all    = 1'b1;
                        new_pc_c     = exp_vector_q[31:2];
                        pre_status_d = {30'b0, int_en_q, exe_mode_q};
                        exe_mode_d   = CPU_KERNEL_MODE;
                        int_en_d     = 1'b0;
                        epc_d        = {pl.mem_pc, 2'b00};
                        cause_d      = (pl.mem_exp_code != ISA_EXP_NO_EXP) ?
                                       pl.mem_exp_code : ISA_EXP_EXT_INT;
                    end else if (pl.mem_ctrl_op == CTRL_OP_EXRT) begin
                        flush_all  = 1'b1;
                        new_pc_c   = epc_q[31:2];
                        int_en_d   = pre_status_q[1];
                        exe_mode_d = pre_status_q[0];
                    end else if (pl.mem_ctrl_op == CTRL_OP_WRCR) begin
                        // Refetch the next instruction so it sees the new value.
                        flush_all = 1'b1;
                        new_pc_c  = pl.mem_pc + 30'd1;
                        case (pl.mem_dst_addr)
                            CREG_STATUS:     {int_en_d, exe_mode_d} = pl.mem_out[1:0];
                            CREG_PRE_STATUS: pre_status_d = pl.mem_out;
                            CREG_EPC:        epc_d        = pl.mem_out;
                            CREG_EXP_VECTOR: exp_vector_d = pl.mem_out;
                            CREG_CAUSE:      cause_d      = pl.mem_out[2:0];
`ifdef PIPELINE_CTRL_IRQ_EN
                            CREG_INT_MASK:   int_mask_d   = pl.mem_out[IRQ_W-1:0];
`endif
                            default: ;
                        endcase
                    end
                end
                // A redirect wins over the hazard: holding IF would drop new_pc.
                hazard_stall = pl.ld_hazard & ~flush_all;
                id_bubble    = pl.ld_hazard & ~stall;
            end
        endcase
    end

    assign pl.if_stall  = stall_all | hazard_stall;
    assign pl.id_stall  = stall_all;
    assign pl.ex_stall  = stall_all;
    assign pl.mem_stall = stall_all;
    assign pl.if_flush  = flush_all;
    assign pl.id_flush  = flush_all | id_bubble;
    assign pl.ex_flush  = flush_all;
    assign pl.mem_flush = flush_all;
    assign pl.new_pc    = new_pc_c;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= ST_BOOT;
            exe_mode_q   <= CPU_KERNEL_MODE;
            int_en_q     <= 1'b0;
            pre_status_q <= 32'h0;
            epc_q        <= 32'h0;
            exp_vector_q <= 32'h0;
            cause_q      <= 3'h0;
`ifdef PIPELINE_CTRL_IRQ_EN
            int_mask_q   <= '1;
`endif
        end else begin
            state_q      <= state_d;
            exe_mode_q   <= exe_mode_d;
            int_en_q     <= int_en_d;
            pre_status_q <= pre_status_d;
            epc_q        <= epc_d;
            exp_vector_q <= exp_vector_d;
            cause_q      <= cause_d;
`ifdef PIPELINE_CTRL_IRQ_EN
            int_mask_q   <= int_mask_d;
`endif
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Self-checking bench for pipeline_ctrl: reset/boot behaviour, a vector
// table of combinational stall/flush cases, hand-written multi-cycle
// sequences (trap, stalled trap, EXRT, interrupt), then randomized traffic
// compared against a control-register-array reference model.
// Follows the PIPELINE_CTRL_IRQ_EN build option of the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_ctrl;
    localparam logic [29:0] RV    = 30'h0012_3456;
    localparam int          IRQ_W = 8;

    logic             clk = 1'b0;
    logic             reset_ = 1'b1;
    logic [4:0]       creg_rd_addr = 5'd0;
    logic [31:0]      creg_rd_data;
    logic             exe_mode;
    logic [IRQ_W-1:0] irq = '0;
    logic             int_detect;

    pipeline_ctrl_if bus();

    pipeline_ctrl #(.RESET_VECTOR(RV), .IRQ_W(IRQ_W)) dut (
        .clk          (clk),
        .reset_       (reset_),
        .pl           (bus),
        .creg_rd_addr (creg_rd_addr),
        .creg_rd_data (creg_rd_data),
        .exe_mode     (exe_mode),
        .irq          (irq),
        .int_detect   (int_detect)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [3:0] stalls();
        return {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall};
    endfunction

    function automatic logic [3:0] flushes();
        return {bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush};
    endfunction

    task automatic idle();
        bus.if_busy      = 1'b0;
        bus.mem_busy     = 1'b0;
        bus.ld_hazard    = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_ctrl_op  = 2'd0;
        bus.mem_dst_addr = 5'd0;
        bus.mem_exp_code = 3'd0;
        bus.mem_out      = 32'h0;
    endtask

    task automatic read_cr(input string name, input logic [4:0] a, input logic [31:0] exp);
        creg_rd_addr = a;
        #1;
        check(name, creg_rd_data, exp);
    endtask

    // One committed WRCR; returns at a negedge with idle inputs.
    task automatic do_wrcr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        idle();
        bus.mem_en = 1'b1; bus.mem_ctrl_op = 2'd1;
        bus.mem_dst_addr = a; bus.mem_out = d; bus.mem_pc = 30'h1000;
        @(negedge clk);
        idle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic ib, mb, ld, en;
        logic [1:0]  op;
        logic [2:0]  ec;
        logic [29:0] pc;
        logic [3:0]  st;   // {if,id,ex,mem}
        logic [3:0]  fl;   // {if,id,ex,mem}
        logic [29:0] npc;
    } vec_t;
    vec_t tbl [12];

    // ---------------- reference model ----------------
    logic [31:0] m_cr [8];
    bit          m_boot;
    int          m_act;            // 0 none, 1 entry, 2 EXRT, 3 WRCR
    logic [2:0]  m_code;
    logic [3:0]  e_stall, e_flush;
    logic [29:0] e_pc;
    logic        e_int;

    task automatic model_reset();
        foreach (m_cr[i]) m_cr[i] = 32'h0;
        m_cr[0] = 32'h1;
`ifdef PIPELINE_CTRL_IRQ_EN
        m_cr[5] = 32'h0000_00FF;
`endif
        m_boot = 1'b1;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd6) begin
`ifdef PIPELINE_CTRL_IRQ_EN
            return 32'(irq);
`else
            return 32'h0;
`endif
        end
        if (a < 5'd8) return m_cr[a[2:0]];
        return 32'h0;
    endfunction

    task automatic model_eval();
        bit stl, go;
        stl   = bus.if_busy || bus.mem_busy;
        e_int = 1'b0;
`ifdef PIPELINE_CTRL_IRQ_EN
        e_int = m_cr[0][1] && ((irq & ~m_cr[5][IRQ_W-1:0]) != '0);
`endif
        m_act = 0;
        if (m_boot) begin
            e_stall = 4'h0; e_flush = 4'hF; e_pc = RV;
        end else begin
            go = !stl && bus.mem_en;
            if (go && bus.mem_exp_code != 3'd0) begin m_act = 1; m_code = bus.mem_exp_code; end
            else if (go && e_int)                begin m_act = 1; m_code = 3'd1; end
            else if (go && bus.mem_ctrl_op == 2'd2) m_act = 2;
            else if (go && bus.mem_ctrl_op == 2'd1) m_act = 3;
            e_flush = (m_act != 0) ? 4'hF : ((bus.ld_hazard && !stl) ? 4'b0100 : 4'b0000);
            e_stall = stl ? 4'hF : ((bus.ld_hazard && m_act == 0) ? 4'b1000 : 4'b0000);
            e_pc = (m_act == 1) ? m_cr[3][31:2] :
                   (m_act == 2) ? m_cr[2][31:2] : bus.mem_pc + 30'd1;
        end
    endtask

    task automatic model_commit();
        if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            case (m_act)
                1: begin
                    m_cr[1] = m_cr[0];
                    m_cr[0] = 32'h1;
                    m_cr[2] = {bus.mem_pc, 2'b00};
                    m_cr[4] = 32'(m_code);
                end
                2: m_cr[0] = m_cr[1] & 32'h3;
                3: case (bus.mem_dst_addr)
                    5'd0: m_cr[0] = bus.mem_out & 32'h3;
                    5'd1, 5'd2, 5'd3: m_cr[bus.mem_dst_addr[2:0]] = bus.mem_out;
                    5'd4: m_cr[4] = bus.mem_out & 32'h7;
`ifdef PIPELINE_CTRL_IRQ_EN
                    5'd5: m_cr[5] = bus.mem_out & 32'hFF;
`endif
                    default: ;
                endcase
                default: ;
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_mask, exp_irq;
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,30'h10,       4'h0,4'h0,30'h0};
        tbl[1]  = '{1'b0,1'b0,1'b1,1'b0,2'd0,3'd0,30'h10,       4'h8,4'h4,30'h0};
        tbl[2]  = '{1'b1,1'b0,1'b1,1'b0,2'd0,3'd0,30'h10,       4'hF,4'h0,30'h0};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b1,2'd1,3'd0,30'h10,       4'hF,4'h0,30'h0};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,2'd1,3'd0,30'h10,       4'h0,4'hF,30'h11};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,2'd1,3'd0,30'h3FFFFFFF, 4'h0,4'hF,30'h0};
        tbl[6]  = '{1'b0,1'b0,1'b1,1'b1,2'd1,3'd0,30'h20,       4'h0,4'hF,30'h21};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,2'd2,3'd5,30'h30,       4'h0,4'hF,30'h40};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,2'd2,3'd0,30'h30,       4'h0,4'hF,30'hC0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,2'd1,3'd5,30'h30,       4'h0,4'h0,30'h0};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b1,2'd0,3'd0,30'h30,       4'h0,4'h0,30'h0};
        tbl[11] = '{1'b1,1'b1,1'b1,1'b1,2'd0,3'd5,30'h30,       4'hF,4'h0,30'h0};

`ifdef PIPELINE_CTRL_IRQ_EN
        exp_mask = 32'hFF; exp_irq = 32'h5A;
`else
        exp_mask = 32'h0;  exp_irq = 32'h0;
`endif
        // ---- asynchronous reset, before any clock edge ----
        idle();
        bus.mem_pc = 30'h0;
        irq = 8'h5A;
        #1 reset_ = 1'b0;
        #2;
        check("reset_flush", 32'(flushes()), 32'hF);
        check("reset_stall", 32'(stalls()), 32'h0);
        check("reset_new_pc", 32'(bus.new_pc), 32'(RV));
        check("reset_int_detect", 32'(int_detect), 32'h0);
        check("reset_exe_mode", 32'(exe_mode), 32'h1);
        read_cr("rst_status", 5'd0, 32'h1);
        read_cr("rst_pre_status", 5'd1, 32'h0);
        read_cr("rst_epc", 5'd2, 32'h0);
        read_cr("rst_exp_vector", 5'd3, 32'h0);
        read_cr("rst_cause", 5'd4, 32'h0);
        read_cr("rst_int_mask", 5'd5, exp_mask);
        read_cr("rst_irq", 5'd6, exp_irq);
        read_cr("rst_reg7", 5'd7, 32'h0);
        read_cr("rst_reg31", 5'd31, 32'h0);

        // ---- boot cycle then RUN ----
        @(negedge clk); reset_ = 1'b1; #1;
        check("boot_flush", 32'(flushes()), 32'hF);
        check("boot_new_pc", 32'(bus.new_pc), 32'(RV));
        @(negedge clk); #1;
        check("run_flush", 32'(flushes()), 32'h0);
        read_cr("run_status", 5'd0, 32'h1);

        // ---- table-driven combinational cases (never reach an edge) ----
        do_wrcr(5'd3, 32'h100);
        do_wrcr(5'd2, 32'h300);
        read_cr("wr_exp_vector", 5'd3, 32'h100);
        read_cr("wr_epc", 5'd2, 32'h300);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.if_busy = tbl[i].ib; bus.mem_busy = tbl[i].mb; bus.ld_hazard = tbl[i].ld;
            bus.mem_en = tbl[i].en; bus.mem_ctrl_op = tbl[i].op; bus.mem_exp_code = tbl[i].ec;
            bus.mem_pc = tbl[i].pc; bus.mem_dst_addr = 5'd7;
            #1;
            check($sformatf("tbl%0d_stall", i), 32'(stalls()), 32'(tbl[i].st));
            check($sformatf("tbl%0d_flush", i), 32'(flushes()), 32'(tbl[i].fl));
            if (tbl[i].fl != 4'h0)
                check($sformatf("tbl%0d_new_pc", i), 32'(bus.new_pc), 32'(tbl[i].npc));
            #1 idle();
        end
        read_cr("tbl_epc_kept", 5'd2, 32'h300);

        // ---- trap ----
        @(negedge clk);
        bus.mem_en = 1'b1; bus.mem_exp_code = 3'd5; bus.mem_pc = 30'h40;
        #1;
        check("trap_flush", 32'(flushes()), 32'hF);
        check("trap_new_pc", 32'(bus.new_pc), 32'h40);
        @(negedge clk); idle();
        read_cr("trap_epc", 5'd2, 32'h100);
        read_cr("trap_cause", 5'd4, 32'h5);
        read_cr("trap_status", 5'd0, 32'h1);
        read_cr("trap_pre_status", 5'd1, 32'h1);

        // ---- trap held off by mem_busy for 3 cycles ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_en = 1'b1; bus.mem_exp_code = 3'd6; bus.mem_pc = 30'h55; bus.mem_busy = 1'b1;
            #1;
            check($sformatf("busy%0d_flush", i), 32'(flushes()), 32'h0);
            read_cr($sformatf("busy%0d_epc", i), 5'd2, 32'h100);
        end
        @(negedge clk);
        bus.mem_busy = 1'b0;
        #1;
        check("busy_release_flush", 32'(flushes()), 32'hF);
        @(negedge clk); idle();
        read_cr("busy_epc", 5'd2, 32'h154);
        read_cr("busy_cause", 5'd4, 32'h6);

        // ---- EXRT ----
        do_wrcr(5'd2, 32'h200);
        do_wrcr(5'd1, 32'h2);
        @(negedge clk);
        bus.mem_en = 1'b1; bus.mem_ctrl_op = 2'd2; bus.mem_pc = 30'h9;
        #1;
        check("exrt_flush", 32'(flushes()), 32'hF);
        check("exrt_new_pc", 32'(bus.new_pc), 32'h80);
        @(negedge clk); idle();
        read_cr("exrt_status", 5'd0, 32'h2);
        check("exrt_exe_mode", 32'(exe_mode), 32'h0);

        // ---- interrupt ----
        irq = 8'h00;
        do_wrcr(5'd5, 32'h0);
        do_wrcr(5'd0, 32'h3);
        irq = 8'h04;
        #1;
`ifdef PIPELINE_CTRL_IRQ_EN
        check("irq_detect", 32'(int_detect), 32'h1);
        read_cr("irq_reg", 5'd6, 32'h04);
`else
        check("irq_detect_off", 32'(int_detect), 32'h0);
        read_cr("irq_mask_off", 5'd5, 32'h0);
`endif
        @(negedge clk);
        bus.mem_en = 1'b1; bus.mem_pc = 30'h77;
        #1;
`ifdef PIPELINE_CTRL_IRQ_EN
        check("irq_flush", 32'(flushes()), 32'hF);
        check("irq_new_pc", 32'(bus.new_pc), 32'h40);
        @(negedge clk); idle();
        read_cr("irq_cause", 5'd4, 32'h1);
        read_cr("irq_status", 5'd0, 32'h1);
        read_cr("irq_pre_status", 5'd1, 32'h3);
        read_cr("irq_epc", 5'd2, 32'h1DC);
        check("irq_detect_cleared", 32'(int_detect), 32'h0);
        do_wrcr(5'd0, 32'h3);
        do_wrcr(5'd5, 32'h04);
        #1;
        check("irq_masked", 32'(int_detect), 32'h0);
`else
        check("irq_flush_off", 32'(flushes()), 32'h0);
        @(negedge clk); idle();
        read_cr("irq_status_off", 5'd0, 32'h3);
        read_cr("irq_cause_off", 5'd4, 32'h6);
`endif

        // ---- mid-run asynchronous reset, then random traffic vs model ----
        @(negedge clk); #1;
        reset_ = 1'b0;
        #1;
        check("areset_flush", 32'(flushes()), 32'hF);
        check("areset_new_pc", 32'(bus.new_pc), 32'(RV));
        @(negedge clk);
        reset_ = 1'b1;
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.if_busy      = ($urandom_range(0, 3) == 0);
            bus.mem_busy     = ($urandom_range(0, 3) == 0);
            bus.ld_hazard    = ($urandom_range(0, 3) == 0);
            bus.mem_en       = ($urandom_range(0, 3) != 0);
            bus.mem_ctrl_op  = 2'($urandom_range(0, 2));
            bus.mem_dst_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(8, 31))
                                                           : 5'($urandom_range(0, 7));
            bus.mem_exp_code = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            bus.mem_pc       = 30'($urandom);
            bus.mem_out      = $urandom;
            irq              = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            creg_rd_addr     = 5'($urandom_range(0, 31));
            #1;
            model_eval();
            check($sformatf("rnd%0d_stall", c), 32'(stalls()), 32'(e_stall));
            check($sformatf("rnd%0d_flush", c), 32'(flushes()), 32'(e_flush));
            if (e_flush[3])
                check($sformatf("rnd%0d_new_pc", c), 32'(bus.new_pc), 32'(e_pc));
            check($sformatf("rnd%0d_int_detect", c), 32'(int_detect), 32'(e_int));
            check($sformatf("rnd%0d_exe_mode", c), 32'(exe_mode), 32'(m_cr[0][0]));
            check($sformatf("rnd%0d_creg%0d", c, creg_rd_addr), creg_rd_data, m_read(creg_rd_addr));
            @(posedge clk);
            model_commit();
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline controller for the five-stage CPU core. It generates per-stage stall and flush signals from the fetch/memory busy lines and the decoder's load-hazard flag. It owns the control-register file that the decoder reads through `creg_rd_addr`/`creg_rd_data`, together with `exe_mode`. It commits WRCR and EXRT and sequences exception and interrupt entry and return from the MEM stage.

## Interface
Parameters:
- RESET_VECTOR, 30'h0, word address that fetch starts from after reset
- IRQ_W, 8, number of external interrupt lines

Ports:
- clk  in  1  core clock
- reset_  in  1  asynchronous, active-low reset
- creg_rd_addr  in  5  control-register read address from the decoder
- creg_rd_data  out  32  control-register read data (combinational)
- exe_mode  out  1  current mode; `CPU_KERNEL_MODE` = 1, user = 0
- if_busy, mem_busy, ld_hazard  in  1 each  fetch wait, memory wait, decoder load-use hazard
- mem_en  in  1  MEM-stage instruction valid
- mem_pc  in  30  MEM-stage instruction word address
- mem_ctrl_op  in  2  `CTRL_OP_NOP`/`CTRL_OP_WRCR`/`CTRL_OP_EXRT`
- mem_dst_addr  in  5  control-register index for WRCR
- mem_exp_code  in  3  `ISA_EXP_*` code carried to MEM
- mem_out  in  32  WRCR write data
- irq  in  IRQ_W  level-sensitive external interrupts
- if_stall, id_stall, ex_stall, mem_stall  out  1 each
- if_flush, id_flush, ex_flush, mem_flush  out  1 each
- new_pc  out  30  redirect target, valid while if_flush = 1
- int_detect  out  1  pending unmasked enabled interrupt

## Operation
- Control registers (index: content):
  - 0 STATUS {30'b0, int_en, exe_mode}
  - 1 PRE_STATUS
  - 2 EPC {mem_pc, 2'b0}
  - 3 EXP_VECTOR
  - 4 CAUSE {29'b0, exp_code}
  - 5 INT_MASK (IRQ_W bits; 1 = masked)
  - 6 IRQ (read-only, raw `irq`)
  - 7-31 read 0; writes are ignored.
- Reset values: STATUS = 32'h1 (kernel, int_en = 0); PRE_STATUS, EPC, EXP_VECTOR and CAUSE = 0; INT_MASK = all ones.
- FSM: BOOT -> RUN.
  - BOOT is entered on reset and lasts exactly one cycle after reset_ deasserts. It asserts all four flushes with new_pc = RESET_VECTOR.
  - RUN: normal operation.
- stall = if_busy | mem_busy.
  - All four *_stall = stall; if_stall also ORs ld_hazard.
  - id_flush is asserted for ld_hazard to inject a bubble, unless stall = 1.
- Commit events are evaluated only in RUN with stall = 0 and mem_en = 1. Priority, highest first:
  1. Exception: mem_exp_code != `ISA_EXP_NO_EXP`.
  2. Interrupt: int_detect.
  3. EXRT.
  4. WRCR.
- Exception or interrupt entry:
  - Flush all stages; new_pc = EXP_VECTOR[31:2].
  - Next edge: PRE_STATUS <= STATUS; exe_mode <= 1; int_en <= 0; EPC <= {mem_pc, 2'b0}.
  - CAUSE <= code, where code is mem_exp_code, or `ISA_EXP_EXT_INT` (3'd1) for an interrupt.
- EXRT:
  - Flush all stages; new_pc = EPC[31:2].
  - Next edge: STATUS <= PRE_STATUS.
- WRCR:
  - CREG[mem_dst_addr] <= mem_out at the next edge.
  - Flush all stages and set new_pc = mem_pc + 1, so that a mode or mask change takes effect on the following instruction.
- int_detect = int_en & |(irq & ~INT_MASK).
- Flush dominates ld_hazard. Stall suppresses all commit events and all flushes, except the flushes asserted in BOOT.

## Timing
- creg_rd_data, all stalls, all flushes, new_pc and int_detect are combinational from current state and inputs. Control-register updates take effect at the next clk rising edge.
- No bypass exists from WRCR to creg_rd_data. Software must not read a register via RDCR in the instruction immediately after a WRCR to the same register. The WRCR flush already enforces this.
- reset_ low asynchronously:
  - All registers are forced to reset values and the state goes to BOOT.
  - Outputs: all flushes = 1, all stalls = 0, new_pc = RESET_VECTOR, int_detect = 0, exe_mode = 1.
- Wrap-around: new_pc = mem_pc + 1 wraps modulo 2^30.

## Configuration
- `PIPELINE_CTRL_IRQ_EN` defined: interrupt detection, INT_MASK and the IRQ register are implemented as described.
- Not defined:
  - int_detect is tied to 0 and irq is ignored.
  - Registers 5 and 6 read 0; writes to them are ignored.
  - No interrupt entry can occur.

## Test plan
- Reset release -> one cycle with all flushes = 1 and new_pc = RESET_VECTOR. Then RUN with no flushes; STATUS reads 32'h1.
- mem_en = 1, mem_exp_code = 3'd5 (TRAP), mem_pc = 30'h40, EXP_VECTOR = 32'h100 -> flush all, new_pc = 30'h40. Next cycle: EPC = 32'h100, CAUSE = 5, STATUS = 32'h1, PRE_STATUS = prior STATUS.
- Same trap with mem_busy = 1 for 3 cycles -> no flush and no register change during those cycles; commit happens in the first cycle with mem_busy = 0.
- WRCR to register 5 with data 0, then irq = 8'h04 with int_en = 1 -> int_detect = 1. Entry occurs with CAUSE = 1 and int_en cleared.
- ld_hazard = 1 with no other event -> if_stall = 1, id_flush = 1, other stalls 0. The same with if_busy = 1 -> all stalls 1, id_flush = 0.
- EXRT with EPC = 32'h200 and PRE_STATUS = 32'h2 -> new_pc = 30'h80, flush all. Next cycle: STATUS = 32'h2, exe_mode = 0.
